// File: rtl/dat_mem_stk.sv
// dat_mem_stk: single-port DW x 2**AW data RAM with combinational load,
// clocked store, and a downward-growing hardware stack carved from the top
// of the array. After reset a sequencer writes the 17-entry bit-mask and
// constant table to core[CONST_BASE..CONST_BASE+16]. All requests are
// ignored while it runs.
//
// Ports:
//   clk      clock, all state changes on posedge
//   rst_n    asynchronous active-low reset
//   wr_en    store enable (core[addr] <= dat_in)
//   addr     load/store address
//   dat_in   store/push data
//   push     push dat_in onto the stack
//   pop      pop the top of the stack
//   dat_out  core[addr]
//   stk_top  current top-of-stack word, 0 when the stack is empty
//   sp       next free stack slot
//   busy     constant-table initialisation in progress
//   stk_ovf  sticky flag: a push was attempted while the stack was full
//   stk_unf  sticky flag: a pop was attempted while the stack was empty
//
// Optional build macro DAT_MEM_REG_RD_EN: dat_out and stk_top are
// registered. They present the pre-edge values one cycle later, give
// read-before-write behaviour, and reset to 0.
module dat_mem_stk #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int CONST_BASE  = 60,
  parameter int STACK_BASE  = 255,
  parameter int STACK_LIMIT = 192
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] dat_in,
  input  logic          push,
  input  logic          pop,
  output logic [DW-1:0] dat_out,
  output logic [DW-1:0] stk_top,
  output logic [AW-1:0] sp,
  output logic          busy,
  output logic          stk_ovf,
  output logic          stk_unf
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [4:0] TBL_LAST = 5'd16;

  state_t        state;
  logic [4:0]    idx;
  logic [DW-1:0] core [2**AW];

  logic          empty, full;
  logic [AW-1:0] sp_up;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  function automatic logic [DW-1:0] tbl(input logic [4:0] i);
    case (i)
      5'd0:    tbl = DW'(8'h10);
      5'd1:    tbl = DW'(8'hE0);
      5'd2:    tbl = DW'(8'hF0);
      5'd3:    tbl = DW'(8'hCC);
      5'd4:    tbl = DW'(8'hAA);
      5'd5:    tbl = DW'(8'h1E);
      5'd6:    tbl = DW'(8'h80);
      5'd7:    tbl = DW'(8'h10);
      5'd8:    tbl = DW'(8'h00);
      5'd9:    tbl = DW'(8'hFF);
      5'd10:   tbl = DW'(8'h08);
      5'd11:   tbl = DW'(8'h40);
      5'd12:   tbl = DW'(8'hF8);
      5'd13:   tbl = DW'(8'h01);
      5'd14:   tbl = DW'(8'h08);
      5'd15:   tbl = DW'(8'h3C);
      5'd16:   tbl = DW'(8'h0F);
      default: tbl = '0;
    endcase
  endfunction

  assign empty = (sp == AW'(STACK_BASE));
  assign full  = (sp == AW'(STACK_LIMIT - 1));
  assign sp_up = sp + AW'(1);

  // Single write port. Priority: init sequencer, then push (a push together
  // with a pop on a non-empty stack rewrites the top slot), then a plain store.
  // Asserting push always drops a concurrent wr_en store.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr;
    mem_wd = dat_in;
    if (state == INIT) begin
      // Suppressed while reset is held so that reset does not touch the RAM.
      mem_we = rst_n;
      mem_wa = AW'(CONST_BASE) + AW'(idx);
      mem_wd = tbl(idx);
    end else if (push) begin
      if (pop && !empty) begin
        mem_we = 1'b1;
        mem_wa = sp_up;
      end else if (!full) begin
        mem_we = 1'b1;
        mem_wa = sp;
      end
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) core[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      idx     <= '0;
      sp      <= AW'(STACK_BASE);
      busy    <= 1'b1;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (state == INIT) begin
      idx <= idx + 5'd1;
      if (idx == TBL_LAST) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end else begin
      if (push && pop) begin
        // A non-empty stack is a top replace with sp held. An empty stack
        // degrades to a plain push and never flags underflow.
        if (empty) sp <= sp - AW'(1);
      end else if (push) begin
        if (full) stk_ovf <= 1'b1;
        else      sp      <= sp - AW'(1);
      end else if (pop) begin
        if (empty) stk_unf <= 1'b1;
        else        sp      <= sp_up;
      end
    end
  end

`ifdef DAT_MEM_REG_RD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_out <= '0;
      stk_top <= '0;
    end else begin
      dat_out <= core[addr];
      stk_top <= empty ? '0 : core[sp_up];
    end
  end
`else
  always_comb begin
    dat_out = core[addr];
    stk_top = empty ? '0 : core[sp_up];
  end
`endif

endmodule
